// File: rtl/idu_queued.sv
// idu_queued: DEPTH-entry instruction queue + head decode + bypassed regfile; define IDU_PERF_CNT_EN for perf counters
module idu_queued #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int NREG  = 32
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_waddr,
  input  logic [XLEN-1:0]          wb_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_rdata1,
  output logic [XLEN-1:0]          out_rdata2,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef IDU_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_issued
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(NREG);
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [XLEN-1:0] rf [NREG];
  logic [PW-1:0] head, tail;
  logic push, pop;
  logic [31:0] hi;
  logic [6:0] op;
  logic i_t, s_t, b_t, u_t, j_t, r_t, wen_ok;
  function automatic logic fit(input logic [4:0] a);
    return int'(a) < NREG;
  endfunction
  function automatic logic ok(input logic [4:0] a);
    return (a != 5'd0) && fit(a);
  endfunction
  assign in_ready  = count != (PW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[tail]    <= in_pc;
      instr_q[tail] <= in_instr;
    end
  // an empty queue decodes an all-zero word, which forces every field to 0
  assign hi        = out_valid ? instr_q[head] : '0;
  assign out_pc    = out_valid ? pc_q[head] : '0;
  assign out_instr = hi;
  assign op        = hi[6:0];
  assign out_rs1   = hi[19:15];
  assign out_rs2   = hi[24:20];
  assign out_rd    = hi[11:7];
  assign i_t = op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011;
  assign s_t = op == 7'b0100011;
  assign b_t = op == 7'b1100011;
  assign u_t = op == 7'b0110111 || op == 7'b0010111;
  assign j_t = op == 7'b1101111;
  assign r_t = op == 7'b0110011;
  always_comb
    out_imm = i_t ? XLEN'($signed(hi[31:20]))
            : s_t ? XLEN'($signed({hi[31:25], hi[11:7]}))
            : b_t ? XLEN'($signed({hi[31], hi[7], hi[30:25], hi[11:8], 1'b0}))
            : u_t ? XLEN'($signed({hi[31:12], 12'b0}))
            : j_t ? XLEN'($signed({hi[31], hi[19:12], hi[20], hi[30:21], 1'b0}))
            : '0;
  assign out_illegal = out_valid && (hi[1:0] != 2'b11 || !(i_t || s_t || b_t || u_t || j_t || r_t)
                       || !fit(out_rs1) || !fit(out_rs2) || !fit(out_rd));
  assign wen_ok = wb_wen && ok(wb_waddr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wen_ok) begin
      rf[wb_waddr[RW-1:0]] <= wb_wdata;
    end
  assign out_rdata1 = !ok(out_rs1) ? '0 : (wb_wen && wb_waddr == out_rs1) ? wb_wdata : rf[out_rs1[RW-1:0]];
  assign out_rdata2 = !ok(out_rs2) ? '0 : (wb_wen && wb_waddr == out_rs2) ? wb_wdata : rf[out_rs2[RW-1:0]];
`ifdef IDU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall  <= '0;
      perf_issued <= '0;
    end else begin
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
      if (pop) perf_issued <= perf_issued + 32'd1;
    end
`endif
endmodule

// File: doc/idu_queued.md
Name: idu_queued

Overview:
- Parametrised successor to the single-register decode stage.
- Replaces the bare IF/ID register with a DEPTH-entry instruction queue using valid/ready handshakes on both sides.
- Decodes the head entry: register indices, immediate and an illegal flag.
- Reads an internal register file with write-back bypass; sits between IFU and EXU, with flush driven by branch resolution.

Parameters:
- XLEN, 32, data/register width.
- PC_W, 32, program counter width.
- DEPTH, 4, queue entries; power of two, >=2.
- NREG, 32, architectural registers; 32 (RV32I) or 16 (RV32E).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  queue can accept.
- in_pc  in  PC_W  PC of offered instruction.
- in_instr  in  32  offered instruction.
- flush  in  1  discard all queued entries.
- wb_wen  in  1  register write enable.
- wb_waddr  in  5  register write index.
- wb_wdata  in  XLEN  register write data.
- out_valid  out  1  head entry is presented.
- out_ready  in  1  EXU consumes head.
- out_pc  out  PC_W  head PC.
- out_instr  out  32  head instruction.
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7].
- out_imm  out  XLEN  sign-extended immediate.
- out_rdata1, out_rdata2  out  XLEN  source operands.
- out_illegal  out  1  head fails decode.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count go to 0; all NREG registers go to 0.
  - Resulting outputs: in_ready=1, out_valid=0, all out_* = 0.
  - Reset asserted mid-operation drops queue contents immediately.
- Push: fires when in_valid && in_ready at a rising edge; writes the entry at the tail; tail wraps modulo DEPTH.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no push-when-full even with a simultaneous pop.
- Pop: fires when out_valid && out_ready; head advances modulo DEPTH.
- Count update: push+pop in the same cycle leaves count unchanged; otherwise +1 or -1.
- out_valid = (count != 0).
- Latency: an entry accepted into an empty queue at edge N is presented with out_valid=1 in the cycle after edge N. There is no combinational in->out path.
- Empty queue: every out_* field is driven 0.
- Flush: at the next edge, count=0 and head=tail=0.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is irrelevant.
  - The register file is unaffected.
- Immediate (from head opcode instr[6:0]):
  - I-type (0010011, 0000011, 1100111, 1110011): sext(instr[31:20]).
  - S-type (0100011): sext({[31:25],[11:7]}).
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],0}).
  - U-type (0110111, 0010111): {[31:12], 12'b0}.
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],0}).
  - Any other opcode: 0.
- Register file:
  - Write at the rising edge when wb_wen && wb_waddr!=0 && wb_waddr<NREG; writes to x0 or to index >=NREG are ignored.
  - Reads are combinational from out_rs1/out_rs2.
  - Index 0 or index >=NREG reads as 0.
- Bypass: if wb_wen && wb_waddr==rsX && rsX!=0 && rsX<NREG, then out_rdataX = wb_wdata in the same cycle.
- out_illegal = out_valid && any of:
  - instr[1:0] != 2'b11;
  - opcode is not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011};
  - any of rs1/rs2/rd >= NREG.
- Illegal entries are still presented and popped normally; the consumer handles the exception.

Optional Feature:
- Macro: IDU_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall (32) and perf_issued (32).
  - perf_stall increments each cycle out_valid && !out_ready.
  - perf_issued increments on each pop.
  - Both counters wrap at 2^32, reset to 0 asynchronously, and are unaffected by flush.
- When undefined: the ports and counters are absent; the rest of the block is identical.

Test Plan:
- Reset, then push {pc=0x80000000, instr=0x00500093 (addi x1,x0,5)} with out_ready=0 -> next cycle: out_valid=1, out_rd=1, out_imm=5, out_illegal=0, count=1.
- Fill with DEPTH=4 pushes while out_ready=0 -> in_ready=0 after the 4th push; a 5th offer is held (count stays 4); then pop 4 -> entries emerge in order and pc wraps correctly.
- Register file write and bypass:
  - wb_wen=1, wb_waddr=3, wb_wdata=0xDEADBEEF while the head is sw x3,0(x2) (0x00312023) -> out_rdata2=0xDEADBEEF in the same cycle.
  - After the write, wb_wen=0 -> out_rdata2 still 0xDEADBEEF.
  - Write to x0 -> reads remain 0.
- flush asserted with count=3 plus a concurrent push -> next cycle count=0, out_valid=0, all out_* = 0.
- NREG=16: head = add x17,x1,x2 (0x002088B3) -> out_illegal=1; instr=0x00000013 with bits[1:0] forced to 00 -> out_illegal=1.
- With IDU_PERF_CNT_EN: hold out_ready=0 for 5 cycles with the queue non-empty, then pop 2 -> perf_stall=5, perf_issued=2.
